sys_bridge_mc: RTL

//  Multi-channel, registered system bridge between the CPU data port and N_DEV memory-mapped

---
 rtl/sys_bridge_mc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sys_bridge_mc.sv
// Registered CPU-to-device bridge: windowed address decode, req/ready handshake per channel, irq synchroniser.
// Optional bus-error timeout on stalled devices is built when BRIDGE_TIMEOUT_EN is defined.
module sys_bridge_mc #(
   parameter int unsigned                N_DEV      = 3,
   parameter int unsigned                ADDR_W     = 32,
   parameter int unsigned                DATA_W     = 32,
   parameter logic [N_DEV*ADDR_W-1:0]    BASE_LIST  = {32'h7f10, 32'h7f00, 32'h0},
   parameter logic [N_DEV*ADDR_W-1:0]    LIMIT_LIST = {32'h7f1b, 32'h7f0b, 32'h2fff},
   parameter int unsigned                TIMEOUT    = 15,
   parameter logic [DATA_W-1:0]          DEFAULT_RD = 32'h12345678
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      cpu_req,
   input  logic                      cpu_we,
   input  logic [ADDR_W-1:0]         cpu_addr,
   input  logic [DATA_W-1:0]         cpu_wdata,
   input  logic [DATA_W/8-1:0]       cpu_be,
   output logic                      cpu_ready,
   output logic [DATA_W-1:0]         cpu_rdata,
   output logic                      cpu_err,
   output logic [N_DEV-1:0]          dev_sel,
   output logic [N_DEV-1:0]          dev_we,
   output logic [ADDR_W-1:0]         dev_addr,
   output logic [DATA_W-1:0]         dev_wdata,
   output logic [DATA_W/8-1:0]       dev_be,
   input  logic [N_DEV*DATA_W-1:0]   dev_rdata,
   input  logic [N_DEV-1:0]          dev_ready,
   input  logic [N_DEV-1:0]          dev_irq,
   output logic [N_DEV-1:0]          hw_int
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata, r_rdata, w_rdata_nxt, w_sel_rdata;
   logic [DATA_W/8-1:0]   r_be;
   logic                  r_we, r_err, w_err_nxt, w_load, w_hit, w_rdy, w_tmo;
   logic [N_DEV-1:0]      r_sel, w_hit_sel, r_sync1, r_sync2;

   // Ascending scan with a found flag so the lowest channel wins on overlapping windows
   always_comb begin
      w_hit     = 1'b0;
      w_hit_sel = '0;
      for (int unsigned i = 0; i < N_DEV; i++) begin
         if (!w_hit && cpu_addr >= BASE_LIST[i*ADDR_W +: ADDR_W] &&
             cpu_addr <= LIMIT_LIST[i*ADDR_W +: ADDR_W]) begin
            w_hit        = 1'b1;
            w_hit_sel[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_rdata = '0;
      for (int unsigned i = 0; i < N_DEV; i++) begin
         if (r_sel[i]) w_sel_rdata = w_sel_rdata | dev_rdata[i*DATA_W +: DATA_W];
      end
   end

   assign w_rdy = |(r_sel & dev_ready);

`ifdef BRIDGE_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
   logic [CNT_W-1:0] r_cnt;

   // Held at zero outside ACCESS, so every ACCESS entry starts a fresh count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                r_cnt <= '0;
      else if (r_state != S_ACCESS) r_cnt <= '0;
      else                         r_cnt <= r_cnt + 1'b1;
   end
   assign w_tmo = (r_state == S_ACCESS) && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_rdata_nxt = r_rdata;
      w_err_nxt   = r_err;
      case (r_state)
         S_IDLE: begin
            if (cpu_req) begin
               w_load = 1'b1;
               if (w_hit) begin
                  w_state_nxt = S_ACCESS;
               end else begin
                  w_state_nxt = S_DONE;
                  w_rdata_nxt = DEFAULT_RD;
                  w_err_nxt   = 1'b1;
               end
            end
         end
         S_ACCESS: begin
            // dev_ready wins over a timeout landing in the same cycle
            if (w_rdy) begin
               w_state_nxt = S_DONE;
               w_rdata_nxt = r_we ? '0 : w_sel_rdata;
               w_err_nxt   = 1'b0;
            end else if (w_tmo) begin
               w_state_nxt = S_DONE;
               w_rdata_nxt = DEFAULT_RD;
               w_err_nxt   = 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_load) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_be    <= cpu_be;
            r_we    <= cpu_we;
         end
         r_sel   <= (w_state_nxt != S_ACCESS) ? '0 : (w_load ? w_hit_sel : r_sel);
         r_rdata <= w_rdata_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= dev_irq;
         r_sync2 <= r_sync1;
      end
   end

   assign cpu_ready = (r_state == S_DONE);
   assign cpu_rdata = r_rdata;
   assign cpu_err   = r_err;
   assign dev_sel   = r_sel;
   assign dev_we    = r_sel & {N_DEV{r_we}};
   assign dev_addr  = r_addr;
   assign dev_wdata = r_wdata;
   assign dev_be    = r_be;
   assign hw_int    = r_sync2;

endmodule
